// File: rtl/letter_scheduler.sv
// rtl/letter_scheduler.sv - falling-letter slot pool: frame motion, spawning, key matching, score/miss tracking
module letter_scheduler #(
  parameter int NUM_SLOTS    = 8,
  parameter int SPAWN_PERIOD = 30,
  parameter int X_LIMIT      = 470,
  parameter int MAX_MISS     = 10,
  localparam int IDX_W       = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [7:0]       gen_ch,
  input  logic [2:0]       gen_speed,
  input  logic [9:0]       gen_y,
  input  logic             key_valid,
  input  logic [7:0]       key_code,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_active,
  output logic [7:0]       rd_ch,
  output logic [8:0]       rd_x,
  output logic [9:0]       rd_y,
  output logic             hit_pulse,
  output logic             wrong_pulse,
  output logic             miss_pulse,
  output logic [15:0]      score,
  output logic [7:0]       miss_cnt,
  output logic             game_over
);
  localparam int CNT_W = $clog2(SPAWN_PERIOD);

  typedef enum logic [2:0] {IDLE, MOVE, SPAWN, KEY_SCAN, KEY_CLEAR} state_t;

  state_t           state, state_n;
  logic             active [NUM_SLOTS];
  logic [7:0]       ch_q   [NUM_SLOTS];
  logic [8:0]       x_q    [NUM_SLOTS];
  logic [9:0]       y_q    [NUM_SLOTS];
  logic [2:0]       spd_q  [NUM_SLOTS];
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] spawn_cnt;
  logic             pend_frame, pend_key;
  logic [7:0]       key_buf;
  logic             best_found;
  logic [IDX_W-1:0] best_idx;
  logic [8:0]       best_x;

  logic [9:0]       nx;
  logic             move_miss, last, spawn_due, halt, accept, scan_match;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  assign rd_active = active[rd_idx];
  assign rd_ch     = ch_q[rd_idx];
  assign rd_x      = x_q[rd_idx];
  assign rd_y      = y_q[rd_idx];

  // halt also covers the cycle between miss_cnt reaching the limit and game_over latching
  assign halt   = game_over || (miss_cnt >= 8'(MAX_MISS));
  assign accept = !(state == IDLE && halt);

  always_comb begin
    state_n     = state;
    hit_pulse   = 1'b0;
    wrong_pulse = 1'b0;
    miss_pulse  = 1'b0;
    nx          = {1'b0, x_q[idx]} + 10'(spd_q[idx]);
    move_miss   = active[idx] && (nx >= 10'(X_LIMIT));
    last        = (idx == IDX_W'(NUM_SLOTS - 1));
    spawn_due   = (spawn_cnt == CNT_W'(SPAWN_PERIOD - 1));
    scan_match  = active[idx] && (ch_q[idx] == key_buf) && (!best_found || x_q[idx] > best_x);
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    case (state)
      IDLE: begin
        if (!halt) begin
          if (pend_frame)    state_n = MOVE;
          else if (pend_key) state_n = KEY_SCAN;
        end
      end
      MOVE: begin
        miss_pulse = (state == MOVE) && move_miss;
        if (last) state_n = spawn_due ? SPAWN : IDLE;
      end
      SPAWN:    state_n = IDLE;
      KEY_SCAN: if (last) state_n = KEY_CLEAR;
      KEY_CLEAR: begin
        hit_pulse   = best_found;
        wrong_pulse = !best_found;
        state_n     = IDLE;
      end
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      spawn_cnt  <= '0;
      pend_frame <= 1'b0;
      pend_key   <= 1'b0;
      key_buf    <= '0;
      best_found <= 1'b0;
      best_idx   <= '0;
      best_x     <= '0;
      score      <= '0;
      miss_cnt   <= '0;
      game_over  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        active[i] <= 1'b0;
        ch_q[i]   <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        spd_q[i]  <= '0;
      end
    end else begin
      state     <= state_n;
      game_over <= game_over || (miss_cnt >= 8'(MAX_MISS));
      case (state)
        IDLE: begin
          best_found <= 1'b0;
          idx        <= '0;
          if (halt) begin
            pend_frame <= 1'b0;
            pend_key   <= 1'b0;
          end else if (pend_frame) begin
            pend_frame <= 1'b0;
          end
        end
        MOVE: begin
          if (move_miss) begin
            active[idx] <= 1'b0;
            ch_q[idx]   <= '0;
            x_q[idx]    <= '0;
            y_q[idx]    <= '0;
            spd_q[idx]  <= '0;
            if (miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
          end else if (active[idx]) begin
            x_q[idx] <= nx[8:0];
          end
          idx <= idx + IDX_W'(1);
          if (last) spawn_cnt <= spawn_due ? '0 : spawn_cnt + CNT_W'(1);
        end
        SPAWN: begin
          if (free_found && !halt) begin
            active[free_idx] <= 1'b1;
            ch_q[free_idx]   <= gen_ch;
            x_q[free_idx]    <= '0;
            y_q[free_idx]    <= gen_y;
            spd_q[free_idx]  <= gen_speed;
          end
        end
        KEY_SCAN: begin
          if (scan_match) begin
            best_found <= 1'b1;
            best_idx   <= idx;
            best_x     <= x_q[idx];
          end
          idx <= idx + IDX_W'(1);
        end
        KEY_CLEAR: begin
          if (best_found) begin
            active[best_idx] <= 1'b0;
            ch_q[best_idx]   <= '0;
            x_q[best_idx]    <= '0;
            y_q[best_idx]    <= '0;
            spd_q[best_idx]  <= '0;
            if (score != 16'hFFFF) score <= score + 16'd1;
          end
          pend_key   <= 1'b0;
          best_found <= 1'b0;
        end
        default: ;
      endcase
      // Latch sets come last so an arrival is never lost to a same-cycle clear,
      // except while halted where all pending work is discarded.
      if (frame_tick && accept) pend_frame <= 1'b1;
      if (key_valid && !pend_key && accept) begin
        pend_key <= 1'b1;
        key_buf  <= key_code;
      end
    end
  end
endmodule

// File: tb/tb_letter_scheduler.sv
// tb/tb_letter_scheduler.sv - randomized bench for letter_scheduler against a transaction-level slot model
module tb_letter_scheduler;
  logic       clk = 1'b0;
  logic       rst, frame_tick, key_valid;
  logic [7:0] gen_ch, key_code;
  logic [2:0] gen_speed;
  logic [9:0] gen_y;
  logic [2:0] rd_idx;
  logic       rd_active, hit_pulse, wrong_pulse, miss_pulse, game_over;
  logic [7:0] rd_ch, miss_cnt;
  logic [8:0] rd_x;
  logic [9:0] rd_y;
  logic [15:0] score;

  letter_scheduler dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gen_ch(gen_ch), .gen_speed(gen_speed),
    .gen_y(gen_y), .key_valid(key_valid), .key_code(key_code), .rd_idx(rd_idx),
    .rd_active(rd_active), .rd_ch(rd_ch), .rd_x(rd_x), .rd_y(rd_y), .hit_pulse(hit_pulse),
    .wrong_pulse(wrong_pulse), .miss_pulse(miss_pulse), .score(score), .miss_cnt(miss_cnt),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  int hits_seen = 0, wrongs_seen = 0, misses_seen = 0;

  always @(negedge clk) begin
    if (rst) begin
      hits_seen = 0; wrongs_seen = 0; misses_seen = 0;
    end else begin
      hits_seen   += int'(hit_pulse);
      wrongs_seen += int'(wrong_pulse);
      misses_seen += int'(miss_pulse);
    end
  end

  // Reference model: whole-frame and whole-key transactions on a slot array
  bit m_act [8];
  int m_ch [8], m_x [8], m_y [8], m_sp [8];
  int m_score, m_miss, m_cnt, e_hit, e_wrong, e_miss;
  bit m_go;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 0; m_ch[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sp[i] = 0;
    end
    m_score = 0; m_miss = 0; m_cnt = 0; m_go = 0;
    e_hit = 0; e_wrong = 0; e_miss = 0;
  endtask

  task automatic model_frame();
    if (m_go) return;
    for (int i = 0; i < 8; i++) begin
      if (m_act[i]) begin
        if (m_x[i] + m_sp[i] >= 470) begin
          m_act[i] = 0;
          e_miss++;
          if (m_miss < 255) m_miss++;
        end else begin
          m_x[i] += m_sp[i];
        end
      end
    end
    if (m_cnt == 29) begin
      m_cnt = 0;
      if (m_miss < 10) begin
        for (int i = 0; i < 8; i++) begin
          if (!m_act[i]) begin
            m_act[i] = 1; m_ch[i] = int'(gen_ch); m_x[i] = 0;
            m_y[i] = int'(gen_y); m_sp[i] = int'(gen_speed);
            break;
          end
        end
      end
    end else begin
      m_cnt++;
    end
    if (m_miss >= 10) m_go = 1;
  endtask

  task automatic model_key(input int k);
    int best;
    if (m_go) return;
    best = -1;
    for (int i = 0; i < 8; i++)
      if (m_act[i] && m_ch[i] == k && (best < 0 || m_x[i] > m_x[best])) best = i;
    if (best >= 0) begin
      m_act[best] = 0;
      e_hit++;
      if (m_score < 65535) m_score++;
    end else begin
      e_wrong++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_score"}, 32'(score), 32'(m_score));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(m_miss));
    check({tag, "_game_over"}, 32'(game_over), 32'(m_go));
    check({tag, "_hits"}, 32'(hits_seen), 32'(e_hit));
    check({tag, "_wrongs"}, 32'(wrongs_seen), 32'(e_wrong));
    check({tag, "_misses"}, 32'(misses_seen), 32'(e_miss));
    for (int i = 0; i < 8; i++) begin
      rd_idx = 3'(i);
      #1;
      check($sformatf("%s_s%0d_act", tag, i), 32'(rd_active), 32'(m_act[i]));
      if (m_act[i]) begin
        check($sformatf("%s_s%0d_ch", tag, i), 32'(rd_ch), 32'(m_ch[i]));
        check($sformatf("%s_s%0d_x", tag, i), 32'(rd_x), 32'(m_x[i]));
        check($sformatf("%s_s%0d_y", tag, i), 32'(rd_y), 32'(m_y[i]));
      end
    end
  endtask

  task automatic do_frame(input int gap);
    frame_tick = 1; tick(); frame_tick = 0;
    model_frame();
    repeat (gap) tick();
  endtask

  // kind: 0 frame, 1 key, 2 frame+key same cycle, 3 key then frame+key mid-scan
  task automatic do_step(input int kind);
    int k1, k2;
    k1 = int'($urandom_range(65, 69));
    k2 = int'($urandom_range(65, 69));
    gen_ch = 8'($urandom_range(65, 68));
    gen_speed = 3'($urandom_range(1, 3));
    gen_y = 10'($urandom_range(0, 639));
    case (kind)
      0: do_frame(14);
      1: begin
        key_valid = 1; key_code = 8'(k1); tick(); key_valid = 0;
        model_key(k1);
        repeat (14) tick();
      end
      2: begin
        frame_tick = 1; key_valid = 1; key_code = 8'(k1); tick();
        frame_tick = 0; key_valid = 0;
        model_frame(); model_key(k1);
        repeat (28) tick();
      end
      default: begin
        key_valid = 1; key_code = 8'(k1); tick(); key_valid = 0;
        repeat (3) tick();
        frame_tick = 1; key_valid = 1; key_code = 8'(k2); tick();
        frame_tick = 0; key_valid = 0;
        model_key(k1); model_frame();
        repeat (28) tick();
      end
    endcase
  endtask

  initial begin
    rst = 1; frame_tick = 0; key_valid = 0; key_code = 0;
    gen_ch = 0; gen_speed = 0; gen_y = 0; rd_idx = 0;
    model_reset();
    repeat (3) tick();
    rst = 0;
    tick();
    check_all("reset");

    gen_ch = 8'h41; gen_speed = 3'd2; gen_y = 10'd90;
    for (int f = 0; f < 30; f++) do_frame(14);
    rd_idx = 3'd0; #1;
    check("first_spawn_act", 32'(rd_active), 32'd1);
    check("first_spawn_ch", 32'(rd_ch), 32'h41);
    check("first_spawn_x", 32'(rd_x), 32'd0);
    check("first_spawn_y", 32'(rd_y), 32'd90);
    rd_idx = 3'd1; #1;
    check("first_spawn_s1_idle", 32'(rd_active), 32'd0);
    check_all("spawn30");

    for (int s = 0; s < 300; s++) begin
      do_step(int'($urandom_range(0, 3)));
      check_all($sformatf("mix%0d", s));
    end

    for (int s = 0; s < 2500 && !m_go; s++) begin
      do_step(0);
      if (s % 10 == 0) check_all($sformatf("fall%0d", s));
    end
    check_all("go_reached");
    check("game_over_set", 32'(game_over), 32'd1);

    for (int s = 0; s < 20; s++) do_step(int'($urandom_range(0, 3)));
    check_all("frozen");

    gen_ch = 8'h42;
    rst = 1; tick(); rst = 0;
    model_reset();
    tick();
    for (int f = 0; f < 30; f++) do_frame(14);
    key_valid = 1; key_code = 8'h42; tick(); key_valid = 0;
    repeat (4) tick();
    rst = 1; tick(); rst = 0;
    model_reset();
    repeat (20) tick();
    check_all("rst_mid_scan");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/letter_scheduler.md
Name: letter_scheduler

Overview:
- Owns the pool of falling-letter slots for the typing game.
- Samples the letter generator's ch/speed/y outputs to spawn letters at a fixed frame cadence, and advances every active letter's x by its speed once per frame.
- Retires letters that reach the bottom (miss) or match a typed key (hit).
- Exposes a random-access read port for the VGA renderer, plus score, miss and game-over status.

Parameters:
- NUM_SLOTS, 8, number of letter slots (power of two; index width IDX_W = log2(NUM_SLOTS)).
- SPAWN_PERIOD, 30, frames between spawn attempts.
- X_LIMIT, 470, x value at or beyond which a letter is missed.
- MAX_MISS, 10, miss count that triggers game_over.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- gen_ch  in  8  generator letter code (ASCII 'A'..'Z')
- gen_speed  in  3  generator speed, 1..3
- gen_y  in  10  generator column position
- key_valid  in  1  one-cycle strobe, key_code valid
- key_code  in  8  ASCII code of typed key
- rd_idx  in  IDX_W  renderer slot select
- rd_active  out  1  selected slot occupied
- rd_ch  out  8  selected slot letter
- rd_x  out  9  selected slot vertical position
- rd_y  out  10  selected slot column
- hit_pulse  out  1  one cycle, key matched a letter
- wrong_pulse  out  1  one cycle, key matched nothing
- miss_pulse  out  1  one cycle per letter reaching X_LIMIT
- score  out  16  hits, saturating at 65535
- miss_cnt  out  8  misses, saturating at 255
- game_over  out  1  latched when miss_cnt >= MAX_MISS

Behaviour:
- Reset: synchronous, active-high. All slots inactive, ch/x/y/speed = 0. score = 0, miss_cnt = 0, spawn counter = 0, game_over = 0, all pulses = 0, pending flags cleared, FSM = IDLE. rst mid-scan aborts the scan with no partial slot update.
- Read port is combinational from slot storage; rd_* reflect register contents in the same cycle rd_idx changes.
- FSM states: IDLE, MOVE, SPAWN, KEY_SCAN, KEY_CLEAR.
- Pending latches:
  - frame_tick sets pend_frame.
  - key_valid sets pend_key and captures key_code into a 1-deep buffer, but only when pend_key = 0. A second key while pending is dropped.
  - Both latches are captured in any state.
- IDLE: if game_over, stay and clear pend_* each cycle. Else if pend_frame, go to MOVE with index 0 (pend_frame cleared). Else if pend_key, go to KEY_SCAN with index 0. Frame work has priority over key work.
- MOVE: one slot per cycle, NUM_SLOTS cycles. For each active slot, nx = x + speed computed at 10 bits.
  - If nx >= X_LIMIT: slot cleared, miss_pulse = 1 that cycle, miss_cnt += 1 (saturating).
  - Else x <= nx[8:0].
  - Inactive slots are untouched.
  - After the last slot, spawn counter increments. If it equals SPAWN_PERIOD-1, the counter resets to 0 and the FSM goes to SPAWN; else IDLE.
- SPAWN (1 cycle): lowest-index inactive slot is loaded with gen_ch, gen_speed, gen_y sampled that cycle, x = 0, active = 1. If all slots are active, the spawn is skipped silently (counter already reset). Next state IDLE.
- KEY_SCAN: NUM_SLOTS cycles, one slot per cycle. Tracks the best match: active and ch == buffered key. Best is largest x; ties go to the lower index.
- KEY_CLEAR (1 cycle):
  - If a match was found: slot cleared, hit_pulse = 1, score += 1 (saturating).
  - Else wrong_pulse = 1.
  - pend_key cleared; next state IDLE.
- Frame during KEY_SCAN is latched and served from IDLE afterwards. A letter missed in MOVE cannot be hit by a key buffered behind it.
- game_over sets in the cycle after miss_cnt reaches MAX_MISS; it is sticky until rst. When set, the current MOVE pass completes, then no further MOVE/SPAWN/KEY work occurs. Slot contents freeze for display.
- Total frame service latency: NUM_SLOTS+1 cycles (+1 for SPAWN). This must fit well within a frame period.

Test Plan:
- Reset, then 30 frame_ticks with gen_ch=0x41, gen_speed=2, gen_y=90 -> after the 30th tick's SPAWN, slot 0 is active with ch=0x41, x=0, y=90. No other slot is active.
- Slot active with speed=3, then 156 frames -> x=468. Next frame -> slot cleared, one miss_pulse, miss_cnt=1.
- Slots 2 (ch 'K', x=100) and 5 (ch 'K', x=200) active; key_code=0x4B -> slot 5 cleared, hit_pulse, score=1. Second 'K' -> slot 2 cleared. Third 'K' -> wrong_pulse, score unchanged.
- All 8 slots active, spawn due -> no slot changes, spawn counter back to 0, no pulse.
- frame_tick and key_valid in the same cycle as an in-progress KEY_SCAN -> key finishes first, then MOVE runs. A third key during this is dropped (no pulse).
- MAX_MISS=10: 10 misses -> game_over=1. Subsequent frame_ticks and keys leave slots, score and miss_cnt unchanged. rst clears everything.
